// File: rtl/chunked_serial_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder_if
//   Handshake and data bundle for the chunked serial add/subtract unit.
//   The producer presents operands on the in_* side. The consumer takes
//   results from the out_* side.
//
//   Signals
//     in_valid   producer -> unit   operands valid
//     in_ready   unit -> producer   unit can accept operands
//     a, b       producer -> unit   WIDTH-bit operands
//     cin        producer -> unit   carry in (ignored when sub=1)
//     sub        producer -> unit   0: a+b+cin, 1: a-b
//     out_valid  unit -> consumer   result valid
//     out_ready  consumer -> unit   consumer accepts result
//     sum        unit -> consumer   WIDTH-bit result
//     cout       unit -> consumer   carry out of the MSB (1 = no borrow on sub)
//     ovf        unit -> consumer   signed overflow flag
//
//   Modports
//     master  environment side (drives operands and out_ready)
//     slave   adder side
// ---------------------------------------------------------------------------
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//   Multi-cycle WIDTH-bit add/subtract unit. Each clock processes CHUNK bits,
//   starting with the LSB chunk. A registered carry links one chunk to the
//   next. Subtraction is computed as a + ~b + 1. WIDTH must be a multiple
//   of CHUNK.
//
//   Parameters
//     WIDTH  operand/result width (default 32)
//     CHUNK  bits added per clock (default 8)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    chunked_serial_adder_if.slave
//            (in_valid/in_ready/a/b/cin/sub,
//             out_valid/out_ready/sum/cout/ovf)
//
//   Optional feature
//     CHUNKED_ADDER_OVF_EN
//       When defined, ovf reports signed overflow. It is the carry into the
//       MSB XOR the carry out of the MSB, taken from the last chunk.
//       When undefined, ovf is tied to 0.
// ---------------------------------------------------------------------------
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  chunked_serial_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CHUNK:0]   chunk_sum;
`ifdef CHUNKED_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  // The operand registers shift right by CHUNK every RUN cycle, so the
  // active chunk is always in the low bits. No variable part-select is needed.
  assign chunk_sum = {1'b0, op_a_q[CHUNK-1:0]}
                   + {1'b0, op_b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

`ifdef CHUNKED_ADDER_OVF_EN
  // The carry into a bit is the XOR of its two inputs and its sum bit.
  assign msb_cin = op_a_q[CHUNK-1] ^ op_b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
`endif

  // rdy_q holds in_ready low during reset and sets at the first edge after
  // reset is released.
  assign bus.in_ready  = rdy_q && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && rdy_q) begin
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          part_d  = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> CHUNK;
        op_b_d  = op_b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        // Each new chunk enters at the top of the result register.
        // After NCHUNK shifts, every chunk sits in its final position.
        part_d  = (part_q >> CHUNK)
                | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          sum_d   = part_d;
          cout_d  = chunk_sum[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
          ovf_d   = msb_cin ^ chunk_sum[CHUNK];
`endif
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_serial_adder
//   Directed bench for chunked_serial_adder. It drives two instances:
//     dut32  WIDTH=32 CHUNK=8   (4 chunks per operation)
//     dut16  WIDTH=16 CHUNK=16  (single-chunk operation)
//   The bench expects ovf values that match the CHUNKED_ADDER_OVF_EN setting.
// ---------------------------------------------------------------------------
module tb_chunked_serial_adder;
  localparam int NCHUNK32 = 4;
`ifdef CHUNKED_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   num_checks;
  int   num_fails;
  logic [31:0] prev_sum;

  chunked_serial_adder_if #(.WIDTH(32)) bus32 ();
  chunked_serial_adder_if #(.WIDTH(16)) bus16 ();

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This watchdog stops the run if the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one operation on dut32. The task checks handshakes every cycle,
  // the latency and the result. With hold_cycles > 0, it also applies
  // back-pressure and presents new operands that the unit must ignore.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub,
                               input logic [31:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf,
                               input int hold_cycles, input string tag);
    int wait_cnt;
    int lat;
    @(negedge clk);
    bus32.out_ready = (hold_cycles == 0);
    wait_cnt = 0;
    while (!bus32.in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput({tag, ".in_ready_idle"}, 32'(bus32.in_ready), 32'd1);
    bus32.in_valid = 1'b1;
    bus32.a        = a;
    bus32.b        = b;
    bus32.cin      = cin;
    bus32.sub      = sub;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus32.a        = ~a;
    bus32.b        = ~b;
    bus32.cin      = ~cin;
    lat = 0;
    while (!bus32.out_valid && lat < 20) begin
      checkOutput({tag, ".in_ready_run"}, 32'(bus32.in_ready), 32'd0);
      checkOutput({tag, ".sum_run"}, bus32.sum, prev_sum);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(NCHUNK32));
    checkOutput({tag, ".sum"}, bus32.sum, exp_sum);
    checkOutput({tag, ".cout"}, 32'(bus32.cout), 32'(exp_cout));
    checkOutput({tag, ".ovf"}, 32'(bus32.ovf), 32'(exp_ovf & OVF_ON));
    for (int h = 0; h < hold_cycles; h++) begin
      bus32.in_valid = 1'b1;
      bus32.a        = 32'h1111_1111;
      bus32.b        = 32'h2222_2222;
      @(negedge clk);
      checkOutput({tag, ".hold_valid"}, 32'(bus32.out_valid), 32'd1);
      checkOutput({tag, ".hold_in_ready"}, 32'(bus32.in_ready), 32'd0);
      checkOutput({tag, ".hold_sum"}, bus32.sum, exp_sum);
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".valid_drop"}, 32'(bus32.out_valid), 32'd0);
    checkOutput({tag, ".in_ready_back"}, 32'(bus32.in_ready), 32'd1);
    checkOutput({tag, ".sum_kept"}, bus32.sum, exp_sum);
    prev_sum = exp_sum;
  endtask

  initial begin
    int wait_cnt;
    logic [15:0] w_a[2];
    logic [15:0] w_b[2];
    logic        w_cin[2];
    logic [15:0] w_sum[2];
    logic        w_cout[2];
    logic        w_ovf[2];

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7]  = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0};
    vecs[10] = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 32'hCC79_6877, 1'b1, 1'b0};

    w_a[0] = 16'h8000; w_b[0] = 16'h8000; w_cin[0] = 1'b0;
    w_sum[0] = 16'h0000; w_cout[0] = 1'b1; w_ovf[0] = 1'b1;
    w_a[1] = 16'h1234; w_b[1] = 16'h4321; w_cin[1] = 1'b1;
    w_sum[1] = 16'h5556; w_cout[1] = 1'b0; w_ovf[1] = 1'b0;

    num_checks = 0;
    num_fails  = 0;
    prev_sum   = 32'h0;
    rst_n      = 1'b0;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
    bus32.sub = 1'b0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus16.sub = 1'b0; bus16.out_ready = 1'b1;

    // Reset state, and in_ready held low until the first edge after release.
    #1;
    checkOutput("rst.in_ready", 32'(bus32.in_ready), 32'd0);
    checkOutput("rst.out_valid", 32'(bus32.out_valid), 32'd0);
    checkOutput("rst.sum", bus32.sum, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel.in_ready_low", 32'(bus32.in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rel.in_ready_high", 32'(bus32.in_ready), 32'd1);

    $display("[TB] running %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf,
                    0, $sformatf("vec%0d", i));
    end

    // Back-pressure: DONE is held for 5 cycles while new operands are offered.
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                  32'h0001_0000, 1'b0, 1'b0, 5, "hold");

    // Load a non-zero result with cout=1 so that the reset clear is visible.
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1,
                  32'hCC79_6877, 1'b1, 1'b0, 0, "prerst");

    // Asynchronous reset two cycles into RUN.
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h0000_0001;
    bus32.cin = 1'b0; bus32.sub = 1'b0;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.out_valid", 32'(bus32.out_valid), 32'd0);
    checkOutput("midrst.in_ready", 32'(bus32.in_ready), 32'd0);
    checkOutput("midrst.sum", bus32.sum, 32'd0);
    checkOutput("midrst.cout", 32'(bus32.cout), 32'd0);
    checkOutput("midrst.ovf", 32'(bus32.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst.rel_low", 32'(bus32.in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst.rel_high", 32'(bus32.in_ready), 32'd1);
    prev_sum = 32'h0;
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0,
                  32'h0000_0003, 1'b0, 1'b0, 0, "postrst");

    // Single-chunk instance: RUN lasts exactly one cycle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wait_cnt = 0;
      while (!bus16.in_ready && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      checkOutput($sformatf("w%0d.in_ready", i), 32'(bus16.in_ready), 32'd1);
      bus16.in_valid = 1'b1;
      bus16.a = w_a[i]; bus16.b = w_b[i]; bus16.cin = w_cin[i]; bus16.sub = 1'b0;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      checkOutput($sformatf("w%0d.valid_lat0", i), 32'(bus16.out_valid), 32'd0);
      checkOutput($sformatf("w%0d.busy", i), 32'(bus16.in_ready), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("w%0d.valid_lat1", i), 32'(bus16.out_valid), 32'd1);
      checkOutput($sformatf("w%0d.sum", i), 32'(bus16.sum), 32'(w_sum[i]));
      checkOutput($sformatf("w%0d.cout", i), 32'(bus16.cout), 32'(w_cout[i]));
      checkOutput($sformatf("w%0d.ovf", i), 32'(bus16.ovf), 32'(w_ovf[i] & OVF_ON));
      @(negedge clk);
      checkOutput($sformatf("w%0d.idle", i), 32'(bus16.in_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             num_checks, num_fails);
    $finish;
  end
endmodule
